// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle RV32I control FSM with memory handshakes, wait timeout, fault and retire count
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iRun,
  input  logic             iImemReady,
  input  logic             iDmemReady,
  input  logic             iOpcodeValid,
  input  logic             iMemRd,
  input  logic             iMemWr,
  input  logic             iRegWrite,
  input  logic             iBranch,
  input  logic             iJump,
  input  logic             iBranchTaken,
  input  logic             iFaultClr,
  output logic             oImemReq,
  output logic             oIrWrite,
  output logic             oDmemReq,
  output logic             oDmemWe,
  output logic             oRegWriteEn,
  output logic             oPcWrite,
  output logic             oPcSel,
  output logic [2:0]       oState,
  output logic             oFault,
  output logic [CNT_W-1:0] oRetired
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd7
  } state_t;
  localparam int WW = $clog2(TIMEOUT + 2);
  state_t state, nextState;
  logic [WW-1:0] waitCnt;
  logic [CNT_W-1:0] retiredCnt;
  logic req, ready, expired;
  logic imemReq, irWrite, dmemReq, dmemWe, regWriteEn, pcWrite, pcSel, fault;
  // pending memory request, its ready, and timeout on the last allowed wait cycle (ready wins)
  always_comb begin
    req = (state == FETCH && iRun) || state == MEM;
    ready = state == FETCH ? iImemReady : iDmemReady;
    expired = TIMEOUT != 0 && req && !ready && waitCnt == WW'(TIMEOUT - 1);
  end
  // next-state and phase-gated strobes
  always_comb begin
    nextState = state;
    imemReq = 1'b0;
    irWrite = 1'b0;
    dmemReq = 1'b0;
    dmemWe = 1'b0;
    regWriteEn = 1'b0;
    pcWrite = 1'b0;
    pcSel = 1'b0;
    fault = 1'b0;
    case (state)
      FETCH: begin
        imemReq = iRun;
        irWrite = iRun & iImemReady;
        nextState = irWrite ? DECODE : expired ? FAULT : FETCH;
      end
      DECODE: nextState = iOpcodeValid ? EXEC : FAULT;
      EXEC: begin
        pcWrite = !(iMemRd || iMemWr || iRegWrite);
        pcSel = pcWrite & iBranch & iBranchTaken;
        nextState = (iMemRd || iMemWr) ? MEM : iRegWrite ? WB : FETCH;
      end
      MEM: begin
        dmemReq = 1'b1;
        dmemWe = iMemWr;
        pcWrite = iDmemReady & !iMemRd;
        nextState = iDmemReady ? (iMemRd ? WB : FETCH) : expired ? FAULT : MEM;
      end
      WB: begin
        regWriteEn = 1'b1;
        pcWrite = 1'b1;
        pcSel = iJump;
        nextState = FETCH;
      end
      FAULT: begin
        fault = 1'b1;
        nextState = iFaultClr ? FETCH : FAULT;
      end
      default: nextState = FAULT;
    endcase
  end
  // state, wait counter (cleared on every state change) and retire counter
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= FETCH;
      waitCnt <= '0;
      retiredCnt <= '0;
    end else begin
      state <= nextState;
      waitCnt <= nextState != state ? '0 : (req && !ready) ? waitCnt + WW'(1) : waitCnt;
      retiredCnt <= retiredCnt + CNT_W'(pcWrite);
    end
  end
  assign oImemReq = iRstN & imemReq;
  assign oIrWrite = iRstN & irWrite;
  assign oDmemReq = iRstN & dmemReq;
  assign oDmemWe = iRstN & dmemWe;
  assign oRegWriteEn = iRstN & regWriteEn;
  assign oPcWrite = iRstN & pcWrite;
  assign oPcSel = iRstN & pcSel;
  assign oFault = iRstN & fault;
  assign oState = state;
  assign oRetired = retiredCnt;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I core. It steps the shared datapath (PC, IR, ALU, register file, instruction/data memory ports) through fetch, decode, execute, memory and writeback phases, one instruction at a time. It consumes the per-opcode control bits from the combinational instruction decoder and gates them into phase-correct enables. It adds memory handshakes, a wait timeout, fault handling and a retired-instruction counter.

## Interface
- TIMEOUT, 16, maximum cycles a memory request may wait for ready; 0 disables the timeout
- CNT_W, 32, width of retired-instruction counter
- iClk  in  1  clock; all state changes on rising edge
- iRstN  in  1  asynchronous active-low reset
- iRun  in  1  permits starting a new fetch
- iImemReady  in  1  instruction memory data valid / request accepted
- iDmemReady  in  1  data memory access complete
- iOpcodeValid  in  1  decoder recognized the opcode in IR
- iMemRd, iMemWr, iRegWrite, iBranch, iJump  in  1 each  decoder control bits for the current IR
- iBranchTaken  in  1  branch comparison result from ALU, valid in EXEC
- iFaultClr  in  1  leaves FAULT
- oImemReq  out  1  instruction fetch request
- oIrWrite  out  1  latch instruction register
- oDmemReq  out  1  data memory request
- oDmemWe  out  1  data memory write enable, qualified by oDmemReq
- oRegWriteEn  out  1  register file write strobe
- oPcWrite  out  1  update PC; marks instruction retirement
- oPcSel  out  1  0 = PC+4, 1 = computed target
- oState  out  3  current state encoding
- oFault  out  1  sequencer is in FAULT
- oRetired  out  CNT_W  retired-instruction count

## Operation
- Reset is asynchronous and active-low. While iRstN is low: state = FETCH, the wait counter and oRetired = 0, and every output is 0, including oImemReq.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7. Codes 5 and 6 are illegal and go to FAULT on the next edge.
- Outputs are Moore-decoded from state, qualified only by the inputs named below.
- FETCH:
  - oImemReq = iRun.
  - When iRun and iImemReady are both high: oIrWrite = 1 for that cycle; next state DECODE.
  - While iRun is low: hold in FETCH; the wait counter does not count.
- DECODE: one cycle. If !iOpcodeValid go to FAULT, else go to EXEC.
- EXEC: one cycle.
  - If iMemRd or iMemWr: go to MEM.
  - Else if iRegWrite: go to WB.
  - Else (branch): oPcWrite = 1, oPcSel = iBranch & iBranchTaken; go to FETCH.
- MEM:
  - oDmemReq = 1 and oDmemWe = iMemWr.
  - On iDmemReady with a load: go to WB.
  - On iDmemReady with a store: oPcWrite = 1, oPcSel = 0; go to FETCH.
- WB: oRegWriteEn = 1, oPcWrite = 1, oPcSel = iJump; go to FETCH.
- FAULT:
  - oFault = 1; all other strobes are 0; PC is not advanced.
  - iFaultClr returns to FETCH; the faulting instruction is refetched.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments each cycle a request is asserted without ready.
  - When it reaches TIMEOUT with ready still low, go to FAULT.
  - If ready arrives in the same cycle the limit is reached, ready wins.
- oRetired increments by 1 on every cycle with oPcWrite = 1 and wraps modulo 2^CNT_W. It is not cleared by FAULT.
- iRun deasserting mid-instruction has no effect; the instruction completes, then the sequencer holds in FETCH.
- Decoder inputs must stay stable from DECODE through retirement. IR is only written in FETCH.

## Timing
- Zero-wait latencies, counted from the FETCH cycle to the retire cycle inclusive:
  - branch: 3 cycles
  - ALU op, LUI, AUIPC, JAL, JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds 1 cycle.
- A ready asserted in the same cycle as its request completes the access in that cycle (zero-wait).
- oIrWrite, oPcWrite and oRegWriteEn are single-cycle pulses per instruction.
- oPcWrite and oRegWriteEn coincide in WB.
- Fault entry is visible on oFault one cycle after the detecting cycle.
- Asserting iRstN low in any state returns to reset values immediately, with no completion of the in-flight access.

## Test plan
- ADD, iRun = 1, both memories zero-wait: state sequence 0,1,2,4,0; oRegWriteEn and oPcWrite high in cycle 4 with oPcSel = 0; oRetired 0 → 1.
- Load with iDmemReady delayed 3 cycles: oDmemReq held high for 4 cycles in MEM, then WB; total 8 cycles; oDmemWe = 0 throughout.
- Taken BEQ (iBranch = 1, iBranchTaken = 1): retires in EXEC with oPcSel = 1 and no oRegWriteEn. Repeat not-taken: oPcSel = 0.
- TIMEOUT = 4 with iImemReady stuck low: oFault = 1 after 4 request cycles. Pulse iFaultClr: back in FETCH with oRetired unchanged. Ready arriving on exactly the 4th cycle: no fault.
- iOpcodeValid = 0 in DECODE → FAULT; oPcWrite never asserted; oState = 7.
- Reset mid-MEM of a store: all outputs 0 immediately and oDmemReq drops asynchronously. After release with iRun = 0: holds in FETCH with oImemReq = 0.
